// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, register-file write driver and one-cycle writeback bypass.
// Optional retired-instruction counter is enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid,
  input  logic              in_RegWrite,
  input  logic              in_MemtoReg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [ADDR_W-1:0] in_write_reg,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_valid,
  output logic              byp_we,
  output logic [ADDR_W-1:0] byp_waddr,
  output logic [DATA_W-1:0] byp_wdata
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  logic              valid_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [ADDR_W-1:0] write_reg_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      alu_result_q <= '0;
      mem_data_q   <= '0;
      write_reg_q  <= '0;
    end else if (flush_i) begin
      // Flush takes priority over stall so a squashed instruction never lingers.
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      alu_result_q <= '0;
      mem_data_q   <= '0;
      write_reg_q  <= '0;
    end else if (!stall_i) begin
      valid_q      <= in_valid;
      regwrite_q   <= in_RegWrite & in_valid;
      memtoreg_q   <= in_MemtoReg;
      alu_result_q <= in_alu_result;
      mem_data_q   <= in_mem_data;
      write_reg_q  <= in_write_reg;
    end
  end

  // Register 0 is hardwired to zero, so writes to it are dropped here.
  assign rf_we    = valid_q & regwrite_q & (write_reg_q != '0);
  assign rf_waddr = write_reg_q;
  assign rf_wdata = memtoreg_q ? mem_data_q : alu_result_q;
  assign wb_valid = valid_q;

  // A held instruction is already in the register file, so the bypass is
  // disabled while stalled to avoid re-forwarding it.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_we    <= 1'b0;
      byp_waddr <= '0;
      byp_wdata <= '0;
    end else begin
      byp_we    <= rf_we & ~stall_i;
      byp_waddr <= rf_waddr;
      byp_wdata <= rf_wdata;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (!flush_i && !stall_i && in_valid && (retire_cnt != '1)) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback driver for the 5-stage pipelined CPU. It captures the writeback control bits (`RegWrite`, `MemtoReg`) decoded for each instruction, along with the ALU result, load data and destination register. From these it drives the register-file write port one cycle later. It also holds the most recent retired write for one extra cycle, so the ID stage can bypass a register file that reads before it writes.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `ADDR_W`, 5, register index width
- `CNT_W`, 32, retire counter width (used only with `MEM_WB_RETIRE_CNT_EN`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `stall_i` in 1: hold stage contents
- `flush_i` in 1: squash the incoming instruction
- `in_valid` in 1: MEM stage holds a real instruction
- `in_RegWrite` in 1: instruction writes the register file
- `in_MemtoReg` in 1: write data comes from memory, not the ALU
- `in_alu_result` in DATA_W: ALU result from EX/MEM
- `in_mem_data` in DATA_W: load data from data memory
- `in_write_reg` in ADDR_W: destination register
- `rf_we` out 1: register-file write enable
- `rf_waddr` out ADDR_W: register-file write address
- `rf_wdata` out DATA_W: register-file write data
- `wb_valid` out 1: stage holds a valid instruction
- `byp_we` out 1: previous-cycle write is available for bypass
- `byp_waddr` out ADDR_W: previous-cycle write address
- `byp_wdata` out DATA_W: previous-cycle write data
- `retire_cnt` out CNT_W: retired-instruction count (present only with `MEM_WB_RETIRE_CNT_EN`)

## Operation
Stage register update, on each rising `clk`, in priority order:
- `rst`: all stage and bypass registers cleared to 0.
- `flush_i`: `valid`←0 and `RegWrite`←0. Other fields are don't-care and are cleared to 0. Flush wins over stall.
- `stall_i`: all stage registers hold.
- Otherwise, capture all inputs:
  - `valid`←`in_valid`
  - `RegWrite`←`in_RegWrite & in_valid`

Combinational outputs:
- `rf_we` = `valid & RegWrite & (waddr != 0)`. Writes to register 0 are suppressed.
- `rf_waddr` = stored `write_reg`.
- `rf_wdata` = stored `MemtoReg` ? stored `mem_data` : stored `alu_result`.
- `wb_valid` = stored `valid`.

Bypass register, updated every non-reset cycle:
- `byp_we`←`rf_we & !stall_i`
- `byp_waddr`←`rf_waddr`
- `byp_wdata`←`rf_wdata`
- During stall the bypass sees `byp_we`=0. A held instruction rewrites the same value each cycle, which is idempotent, and the register file already holds it.

## Timing
- Latency: inputs presented in cycle N appear on `rf_*` in cycle N+1 (registered), and on `byp_*` in cycle N+2.
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `wb_valid`=0, `byp_we`=0, `byp_waddr`=0, `byp_wdata`=0, `retire_cnt`=0.
- Simultaneous `flush_i` and `stall_i`: flush applies, and the stage becomes a bubble next cycle.
- `rst` asserted mid-operation: outputs are 0 at the next edge. An in-flight write in that cycle is lost, and no partial write occurs after the edge.
- `in_valid`=0 with `in_RegWrite`=1: the stage captures a bubble, so `rf_we`=0.
- There is no backpressure from the register file. Its write is assumed to complete in the cycle `rf_we` is high.

## Configuration
- `MEM_WB_RETIRE_CNT_EN` defined:
  - `retire_cnt` port and register exist.
  - The counter increments by 1 on each edge where the stage captures `in_valid`=1 (no `rst`, no `flush_i`, no `stall_i`).
  - It saturates at 2^CNT_W−1 and clears on `rst`.
- Undefined: port and counter are omitted. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with all inputs at all-ones → every output is 0 during and one cycle after reset.
- ALU writeback: `in_valid`=1, `in_RegWrite`=1, `in_MemtoReg`=0, `in_alu_result`=0x0000_1234, `in_write_reg`=5 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234; cycle after that `byp_we`=1, `byp_wdata`=0x1234.
- Load writeback: `in_MemtoReg`=1, `in_mem_data`=0xDEAD_BEEF, `in_alu_result`=0x10, `in_write_reg`=8 → `rf_wdata`=0xDEADBEEF, `rf_waddr`=8.
- Register-0 and bubble suppression:
  - `in_write_reg`=0 with `RegWrite`=1 → `rf_we`=0, `byp_we`=0.
  - `in_valid`=0 with `RegWrite`=1 → `rf_we`=0, `wb_valid`=0.
- Stall/flush:
  - Capture a write to r3, then `stall_i`=1 for 3 cycles → `rf_*` held constant and `byp_we`=0 during stall.
  - Assert `flush_i`=1 together with `stall_i`=1 → next cycle `wb_valid`=0, `rf_we`=0.
- Counter (with macro, CNT_W=4):
  - 20 consecutive valid captures → `retire_cnt` saturates at 15.
  - Flushed or stalled cycles never increment it.
